// File: rtl/memory_store_aligner.sv
`default_nettype none
// ============================================================================
// Module  : memory_store_aligner
// Brief   : Lane-aligns word/half/byte stores, queues them, drains to memory.
//           Optional macro MISALIGN_CHECK_EN drops misaligned stores.
// Revision: 1.0
// ============================================================================
module memory_store_aligner #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_size,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_en,
   input  logic        mem_ack,
   output logic        buf_empty,
   output logic        misalign_err
);

   localparam logic [1:0]     SZ_WORD  = 2'd0;
   localparam logic [1:0]     SZ_HALF  = 2'd1;
   localparam logic [1:0]     SZ_BYTE  = 2'd2;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [29:0]      fifo_addr  [DEPTH];
   logic [31:0]      fifo_wdata [DEPTH];
   logic [3:0]       fifo_be    [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [29:0]      head_addr_q, head_addr_d;
   logic [31:0]      head_wdata_q, head_wdata_d;
   logic [3:0]       head_be_q, head_be_d;

   logic [31:0]      al_wdata;
   logic [3:0]       al_be;
   logic             misaligned;
   logic             accept, push, pop;
   logic [PTR_W:0]   remain;

   always_comb begin
      al_wdata = st_data;
      al_be    = 4'b1111;
      case (st_size)
         SZ_HALF: begin
            al_wdata = {2{st_data[15:0]}};
            al_be    = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         SZ_BYTE: begin
            al_wdata = {4{st_data[7:0]}};
            al_be    = 4'b0001 << st_addr[1:0];
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_CHECK_EN
   logic misalign_err_q;

   // Reserved size 3 behaves as a word, so it is checked like one.
   always_comb begin
      misaligned = 1'b0;
      if ((st_size == SZ_WORD || st_size == 2'd3) && st_addr[1:0] != 2'b00)
         misaligned = 1'b1;
      else if (st_size == SZ_HALF && st_addr[0])
         misaligned = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) misalign_err_q <= 1'b0;
      else          misalign_err_q <= accept && misaligned;
   end

   assign misalign_err = misalign_err_q;
`else
   assign misaligned   = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign st_ready  = (count_q != FULL_CNT);
   assign mem_req   = (count_q != '0);
   assign buf_empty = (count_q == '0);
   assign accept    = st_valid && st_ready;
   assign push      = accept && !misaligned;
   assign pop       = mem_req && mem_ack;

   always_comb begin
      wr_ptr_d     = wr_ptr_q + PTR_W'(push);
      rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
      count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      remain       = count_q - (PTR_W+1)'(pop);
      head_addr_d  = head_addr_q;
      head_wdata_d = head_wdata_q;
      head_be_d    = head_be_q;
      // The head register is only refreshed while something is queued, so the
      // memory-side outputs keep their last value once the FIFO runs dry.
      if (count_d != '0) begin
         if (remain == '0) begin
            head_addr_d  = st_addr[31:2];
            head_wdata_d = al_wdata;
            head_be_d    = al_be;
         end else begin
            head_addr_d  = fifo_addr[rd_ptr_d];
            head_wdata_d = fifo_wdata[rd_ptr_d];
            head_be_d    = fifo_be[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_addr_q  <= '0;
         head_wdata_q <= '0;
         head_be_q    <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_addr_q  <= head_addr_d;
         head_wdata_q <= head_wdata_d;
         head_be_q    <= head_be_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr[wr_ptr_q]  <= st_addr[31:2];
         fifo_wdata[wr_ptr_q] <= al_wdata;
         fifo_be[wr_ptr_q]    <= al_be;
      end
   end

   assign mem_addr    = {head_addr_q, 2'b00};
   assign mem_wdata   = head_wdata_q;
   assign mem_byte_en = head_be_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_store_aligner.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_store_aligner
// Brief   : Vector table plus scoreboard bench for memory_store_aligner.
// Revision: 1.0
// ============================================================================
module tb_memory_store_aligner;

   logic        clock;
   logic        reset_n;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_size;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_en;
   logic        mem_ack;
   logic        buf_empty;
   logic        misalign_err;

   memory_store_aligner #(.DEPTH(2), .PTR_W(1)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_size     (st_size),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_byte_en (mem_byte_en),
      .mem_ack     (mem_ack),
      .buf_empty   (buf_empty),
      .misalign_err(misalign_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   vec_t        vecs [8];
   exp_t        sb [$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] pend_addr;
   logic [31:0] pend_wdata;
   logic [3:0]  pend_be;
   bit          pend_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Model the handshake at the pre-edge instant, then advance one clock.
   task automatic tick();
      exp_t e;
      if (st_valid && st_ready && !pend_drop)
         sb.push_back('{pend_addr, pend_wdata, pend_be});
      if (mem_req && mem_ack) begin
         if (sb.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("pop_addr", mem_addr, e.addr);
            chk("pop_wdata", mem_wdata, e.wdata);
            chk("pop_be", {28'd0, mem_byte_en}, {28'd0, e.be});
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb,
                       input bit drop);
      st_addr = a; st_data = d; st_size = s; st_valid = 1'b1;
      pend_addr = ea; pend_wdata = ew; pend_be = eb; pend_drop = drop;
      for (int n = 0; n < 20 && !st_ready; n++) tick();
      if (!st_ready) chk("st_ready_timeout", {31'd0, st_ready}, 32'd1);
      tick();
      st_valid = 1'b0;
   endtask

   task automatic drain();
      mem_ack = 1'b1;
      for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
      chk("drain_left", sb.size(), 32'd0);
      mem_ack = 1'b0;
      chk("drain_buf_empty", {31'd0, buf_empty}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{32'h0000_1003, 32'h0000_00A5, 2'd2, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
      vecs[1] = '{32'h0000_2002, 32'h0000_BEEF, 2'd1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
      vecs[2] = '{32'h0000_2004, 32'h1234_5678, 2'd0, 32'h0000_2004, 32'h1234_5678, 4'b1111};
      vecs[3] = '{32'h0000_0040, 32'hFFFF_FF3C, 2'd2, 32'h0000_0040, 32'h3C3C_3C3C, 4'b0001};
      vecs[4] = '{32'h0000_0010, 32'hDEAD_1234, 2'd1, 32'h0000_0010, 32'h1234_1234, 4'b0011};
      vecs[5] = '{32'h0000_0050, 32'hCAFE_F00D, 2'd3, 32'h0000_0050, 32'hCAFE_F00D, 4'b1111};
      vecs[6] = '{32'h0000_0006, 32'h0000_0077, 2'd2, 32'h0000_0004, 32'h7777_7777, 4'b0100};
      vecs[7] = '{32'hFFFF_FFFD, 32'h0000_0001, 2'd2, 32'hFFFF_FFFC, 32'h0101_0101, 4'b0010};

      reset_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
      mem_ack = 1'b0; pend_drop = 1'b0; pend_addr = '0; pend_wdata = '0; pend_be = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", {28'd0, mem_byte_en}, 32'd0);
      chk("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Single byte store: latency, lane placement, pop, hold after empty.
      send(32'h0000_1003, 32'h0000_00A5, 2'd2, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 1'b0);
      chk("lat_mem_req", {31'd0, mem_req}, 32'd1);
      chk("lat_mem_addr", mem_addr, 32'h0000_1000);
      chk("lat_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("lat_mem_be", {28'd0, mem_byte_en}, 32'h8);
      chk("lat_buf_empty", {31'd0, buf_empty}, 32'd0);
      tick();
      chk("hold_mem_addr", mem_addr, 32'h0000_1000);
      drain();
      chk("empty_mem_req", {31'd0, mem_req}, 32'd0);
      chk("empty_hold_wdata", mem_wdata, 32'hA5A5_A5A5);

      // Table vectors streamed with ack held high.
      mem_ack = 1'b1;
      for (int i = 0; i < 8; i++)
         send(vecs[i].addr, vecs[i].data, vecs[i].size,
              vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be, 1'b0);
      drain();

      // Back-pressure: third store held off until one ack.
      send(32'h0000_0100, 32'h1111_1111, 2'd0, 32'h0000_0100, 32'h1111_1111, 4'hF, 1'b0);
      send(32'h0000_0104, 32'h2222_2222, 2'd0, 32'h0000_0104, 32'h2222_2222, 4'hF, 1'b0);
      chk("bp_full_ready", {31'd0, st_ready}, 32'd0);
      chk("bp_head_addr", mem_addr, 32'h0000_0100);
      st_addr = 32'h0000_0108; st_data = 32'h3333_3333; st_size = 2'd0; st_valid = 1'b1;
      pend_addr = 32'h0000_0108; pend_wdata = 32'h3333_3333; pend_be = 4'hF; pend_drop = 1'b0;
      tick();
      tick();
      chk("bp_held_ready", {31'd0, st_ready}, 32'd0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("bp_ready_after_ack", {31'd0, st_ready}, 32'd1);
      chk("bp_no_bubble_req", {31'd0, mem_req}, 32'd1);
      chk("bp_next_head", mem_addr, 32'h0000_0104);
      tick();
      st_valid = 1'b0;
      chk("bp_third_taken", {31'd0, st_ready}, 32'd0);
      drain();

      // Continuous push+pop at count=1 across pointer wrap.
      send(32'h0000_0200, 32'hA000_0000, 2'd0, 32'h0000_0200, 32'hA000_0000, 4'hF, 1'b0);
      mem_ack = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(32'h0000_0200 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 2'd0,
              32'h0000_0200 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 4'hF, 1'b0);
         chk("wrap_req", {31'd0, mem_req}, 32'd1);
         chk("wrap_ready", {31'd0, st_ready}, 32'd1);
      end
      drain();

      // Misaligned word store.
`ifdef MISALIGN_CHECK_EN
      send(32'h0000_3001, 32'h1122_3344, 2'd0, 32'h0, 32'h0, 4'h0, 1'b1);
      chk("mis_err_pulse", {31'd0, misalign_err}, 32'd1);
      chk("mis_no_req", {31'd0, mem_req}, 32'd0);
      tick();
      chk("mis_err_clear", {31'd0, misalign_err}, 32'd0);
      send(32'h0000_3003, 32'h0000_5566, 2'd1, 32'h0, 32'h0, 4'h0, 1'b1);
      chk("mis_half_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_half_no_req", {31'd0, mem_req}, 32'd0);
      pend_drop = 1'b0;
`else
      send(32'h0000_3001, 32'h1122_3344, 2'd0, 32'h0000_3000, 32'h1122_3344, 4'hF, 1'b0);
      chk("nomis_err", {31'd0, misalign_err}, 32'd0);
      chk("nomis_req", {31'd0, mem_req}, 32'd1);
      chk("nomis_addr", mem_addr, 32'h0000_3000);
      chk("nomis_be", {28'd0, mem_byte_en}, 32'hF);
      drain();
`endif

      // Asynchronous reset mid-cycle with two entries queued.
      send(32'h0000_4000, 32'h4444_4444, 2'd0, 32'h0000_4000, 32'h4444_4444, 4'hF, 1'b0);
      send(32'h0000_4004, 32'h5555_5555, 2'd0, 32'h0000_4004, 32'h5555_5555, 4'hF, 1'b0);
      chk("prerst_req", {31'd0, mem_req}, 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_req", {31'd0, mem_req}, 32'd0);
      chk("arst_ready", {31'd0, st_ready}, 32'd1);
      chk("arst_empty", {31'd0, buf_empty}, 32'd1);
      chk("arst_addr", mem_addr, 32'd0);
      sb.delete();
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("late_ack_ignored", {31'd0, mem_req}, 32'd0);
      send(32'h0000_5002, 32'h0000_CDEF, 2'd1, 32'h0000_5000, 32'hCDEF_CDEF, 4'b1100, 1'b0);
      chk("post_rst_be", {28'd0, mem_byte_en}, 32'hC);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
